syscall_service_unit: RTL and testbench
=======================================

// Module: syscall_service_unit
// PURPOSE
//  Responder side of the pipeline syscall halt/release handshake. The pipeline raises sys_req
//   with $v0/$a0 when a syscall reaches WB; this block freezes PC/pipeline via stall.
//  It services the call (display $a0, halt until go, or no-op), then releases the pipeline
//   with a one-cycle sys_ack.
//  Sits between the WB stage and the board display/button logic.
// PARAMETERS
//  HOLD_CYCLES  50_000_000  cycles $a0 stays shown for a display syscall; 0 => 1 cycle
//  CNT_W        16          width of the serviced-syscall counter
// PORTS
//  clk          in   1      system clock; all state updates on posedge
//  rst          in   1      asynchronous, active-high reset
//  sys_req      in   1      syscall pending in WB; held high until sys_ack
//  v0           in   32     $v0 (service code), sampled when request accepted
//  a0           in   32     $a0 (argument), sampled when request accepted
//  go           in   1      resume button, already debounced; level input
//  stall        out  1      freeze PC and pipeline registers
//  sys_ack      out  1      one-cycle pulse: syscall serviced, pipeline may proceed
//  halted       out  1      high while waiting in HALT
//  disp_data    out  32     last displayed $a0 (held after SHOW ends)
//  disp_valid   out  1      high while in SHOW
//  sys_cnt      out  CNT_W  number of serviced syscalls, saturating
// BEHAVIOUR
//  Reset: state=IDLE; stall, sys_ack, halted, disp_valid = 0; disp_data, sys_cnt, timer = 0.
//   Reset mid-service aborts the service with no sys_ack.
//  go_q registers go; go_rise = go & ~go_q.
//  IDLE: stall = sys_req (combinational, same-cycle freeze).
//   On sys_req, latch v0/a0 and go to:
//     SHOW (v0==1 or v0==34; timer<=HOLD_CYCLES)
//     HALT (v0==10)
//     CHAR (v0==11, macro only)
//     ACK  (otherwise)
//  SHOW: stall=1, disp_valid=1, disp_data=latched a0.
//   Timer decrements each cycle; timer==0 or go_rise -> ACK.
//  HALT: stall=1, halted=1. Leave only on go_rise -> ACK.
//   go already high on HALT entry does not release; a fresh rising edge is needed.
//  ACK: sys_ack=1, stall=0 for exactly one cycle; sys_cnt += 1 unless all-ones; next IDLE.
//   sys_req is ignored in ACK; the requester drops it on sys_ack.
//   If sys_req is high in the first IDLE cycle after ACK, it is a new syscall.
//  Latency:
//   - unknown code: req cycle + ACK = sys_ack 1 cycle after accept
//   - SHOW: HOLD_CYCLES+1 cycles in SHOW, then ACK
//  v0/a0 changes after accept are ignored; decode uses only latched values.
//  disp_data changes only on SHOW/CHAR entry.
// CONFIGURATION
//  SYSCALL_CHAR_EN defined: v0==11 enters CHAR for one cycle.
//   - disp_data <= {disp_data[23:0], a0[7:0]} (4-char scrolling buffer)
//   - disp_valid=1, stall=1, then ACK
//  SYSCALL_CHAR_EN undefined: v0==11 is an unknown code -> straight to ACK; disp_data unchanged.
// STRUCTURE
//  Shared package mips_pkg:
//   - SYS_PRINT_INT=1, SYS_EXIT=10, SYS_PRINT_CHAR=11, SYS_PRINT_HEX=34
//   - state encoding typedef sys_state_t {IDLE, SHOW, HALT, CHAR, ACK}
//  One sub-module: sys_hold_timer (loadable down-counter, width $clog2(HOLD_CYCLES+1),
//   load/dec/zero ports).
//  FSM, go edge detect, counters in top.
// TESTING (bench with HOLD_CYCLES=4)
//  1. v0=34, a0=0xDEADBEEF, req held:
//     stall same cycle; disp_valid 5 cycles with disp_data=0xDEADBEEF; sys_ack 1 cycle;
//     sys_cnt=1.
//  2. v0=10 with go already high:
//     halted stays 1 for 20 cycles; drop go then raise -> sys_ack next cycle; halted=0.
//  3. v0=5 (unknown): sys_ack 1 cycle after accept; disp_data unchanged; sys_cnt increments.
//  4. rst asserted mid-SHOW: outputs all 0 immediately (async); no sys_ack; sys_cnt=0.
//  5. go_rise in SHOW cycle 2: ACK next cycle, early release.
//     Back-to-back req after ACK is accepted in the next IDLE cycle.
//  6. SYSCALL_CHAR_EN, chars 'M','I','P','S' -> disp_data=0x4D495053.
//     Without macro: disp_data unchanged, 4 acks.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS syscall definitions: service codes and syscall-unit state encoding.
package mips_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
  localparam logic [31:0] SYS_PRINT_HEX  = 32'd34;

  typedef enum logic [2:0] {
    IDLE,
    SHOW,
    HALT,
    CHAR,
    ACK
  } sys_state_t;

endpackage

// File: rtl/sys_hold_timer.sv
// Loadable down-counter that times how long a displayed syscall argument stays visible.
module sys_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  // HOLD_CYCLES of 0 would give a zero-width counter, so keep at least one bit.
  localparam int unsigned W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [W-1:0] HOLD_VAL = W'(HOLD_CYCLES);

  logic [W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (load) begin
      timer_d = HOLD_VAL;
    end else if (dec && (timer_q != '0)) begin
      timer_d = timer_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign zero = (timer_q == '0);

endmodule

// File: rtl/syscall_service_unit.sv
// Syscall responder: stalls the pipeline, services display/halt/no-op calls, then pulses sys_ack.
// Optional feature: define SYSCALL_CHAR_EN to enable the v0==11 scrolling character display.
module syscall_service_unit
  import mips_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sys_req,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  input  logic             go,
  output logic             stall,
  output logic             sys_ack,
  output logic             halted,
  output logic [31:0]      disp_data,
  output logic             disp_valid,
  output logic [CNT_W-1:0] sys_cnt
);

  sys_state_t       state_q, state_d;
  logic             go_q;
  logic [31:0]      disp_data_q, disp_data_d;
  logic [CNT_W-1:0] sys_cnt_q, sys_cnt_d;
  logic             timer_load, timer_zero, go_rise;

  assign go_rise = go & ~go_q;

  sys_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .dec  (state_q == SHOW),
    .zero (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    disp_data_d = disp_data_q;
    sys_cnt_d   = sys_cnt_q;
    timer_load  = 1'b0;
    stall       = 1'b0;
    sys_ack     = 1'b0;
    halted      = 1'b0;
    disp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        // Same-cycle freeze; suppressed while reset is asserted so reset outputs read 0.
        stall = sys_req & ~rst;
        if (sys_req) begin
          case (v0)
            SYS_PRINT_INT, SYS_PRINT_HEX: begin
              state_d     = SHOW;
              disp_data_d = a0;
              timer_load  = 1'b1;
            end
            SYS_EXIT: state_d = HALT;
`ifdef SYSCALL_CHAR_EN
            SYS_PRINT_CHAR: begin
              state_d     = CHAR;
              disp_data_d = {disp_data_q[23:0], a0[7:0]};
            end
`endif
            default: state_d = ACK;
          endcase
        end
      end
      SHOW: begin
        stall      = 1'b1;
        disp_valid = 1'b1;
        if (timer_zero || go_rise) state_d = ACK;
      end
      HALT: begin
        stall  = 1'b1;
        halted = 1'b1;
        if (go_rise) state_d = ACK;
      end
      CHAR: begin
        stall      = 1'b1;
        disp_valid = 1'b1;
        state_d    = ACK;
      end
      ACK: begin
        sys_ack = 1'b1;
        if (~&sys_cnt_q) sys_cnt_d = sys_cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      go_q        <= 1'b0;
      disp_data_q <= '0;
      sys_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      go_q        <= go;
      disp_data_q <= disp_data_d;
      sys_cnt_q   <= sys_cnt_d;
    end
  end

  assign disp_data = disp_data_q;
  assign sys_cnt   = sys_cnt_q;

endmodule

// File: tb/tb_syscall_service_unit.sv
// Directed bench for syscall_service_unit with HOLD_CYCLES=4; honours SYSCALL_CHAR_EN if defined.
module tb_syscall_service_unit;

  logic        clk, rst, sys_req, go;
  logic [31:0] v0, a0;
  logic        stall, sys_ack, halted, disp_valid;
  logic [31:0] disp_data;
  logic [15:0] sys_cnt;

  int tests = 0;
  int fails = 0;

  syscall_service_unit #(
    .HOLD_CYCLES(4),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sys_req   (sys_req),
    .v0        (v0),
    .a0        (a0),
    .go        (go),
    .stall     (stall),
    .sys_ack   (sys_ack),
    .halted    (halted),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .sys_cnt   (sys_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] chars;
    logic [31:0] exp_disp;
    rst = 1'b1; sys_req = 1'b0; go = 1'b0; v0 = '0; a0 = '0;
    tick(); tick();
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_disp_valid", {31'b0, disp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_sys_ack", {31'b0, sys_ack}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_disp_data", disp_data, 32'd0);
    chk("rst_sys_cnt", {16'b0, sys_cnt}, 32'd0);
    tick();

    // 1: print hex, HOLD_CYCLES+1 cycles of display
    v0 = 32'd34; a0 = 32'hDEADBEEF; sys_req = 1'b1;
    #1;
    chk("t1_stall_same_cycle", {31'b0, stall}, 32'd1);
    chk("t1_no_valid_yet", {31'b0, disp_valid}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_show%0d_valid", i), {31'b0, disp_valid}, 32'd1);
      chk($sformatf("t1_show%0d_data", i), disp_data, 32'hDEADBEEF);
      chk($sformatf("t1_show%0d_noack", i), {31'b0, sys_ack}, 32'd0);
      tick();
    end
    chk("t1_ack", {31'b0, sys_ack}, 32'd1);
    chk("t1_ack_stall", {31'b0, stall}, 32'd0);
    chk("t1_ack_valid", {31'b0, disp_valid}, 32'd0);
    sys_req = 1'b0;
    tick();
    chk("t1_ack_done", {31'b0, sys_ack}, 32'd0);
    chk("t1_cnt", {16'b0, sys_cnt}, 32'd1);

    // 2: exit with go already high needs a fresh rising edge
    go = 1'b1;
    tick();
    v0 = 32'd10; a0 = 32'd0; sys_req = 1'b1;
    #1;
    chk("t2_stall", {31'b0, stall}, 32'd1);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t2_halt%0d", i), {31'b0, halted}, 32'd1);
      chk($sformatf("t2_halt%0d_noack", i), {31'b0, sys_ack}, 32'd0);
      tick();
    end
    go = 1'b0;
    tick();
    chk("t2_halt_go_low", {31'b0, halted}, 32'd1);
    go = 1'b1;
    #1;
    chk("t2_halt_go_rise", {31'b0, halted}, 32'd1);
    tick();
    chk("t2_ack", {31'b0, sys_ack}, 32'd1);
    chk("t2_unhalted", {31'b0, halted}, 32'd0);
    sys_req = 1'b0;
    tick();
    chk("t2_cnt", {16'b0, sys_cnt}, 32'd2);
    go = 1'b0;

    // 3: unknown code acks after one cycle
    v0 = 32'd5; a0 = 32'h12345678; sys_req = 1'b1;
    tick();
    chk("t3_ack", {31'b0, sys_ack}, 32'd1);
    chk("t3_disp_kept", disp_data, 32'hDEADBEEF);
    sys_req = 1'b0;
    tick();
    chk("t3_ack_done", {31'b0, sys_ack}, 32'd0);
    chk("t3_cnt", {16'b0, sys_cnt}, 32'd3);

    // 4: asynchronous reset in the middle of SHOW
    v0 = 32'd1; a0 = 32'hCAFEF00D; sys_req = 1'b1;
    tick(); tick();
    chk("t4_in_show", {31'b0, disp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t4_stall", {31'b0, stall}, 32'd0);
    chk("t4_valid", {31'b0, disp_valid}, 32'd0);
    chk("t4_data", disp_data, 32'd0);
    chk("t4_cnt", {16'b0, sys_cnt}, 32'd0);
    chk("t4_halted", {31'b0, halted}, 32'd0);
    sys_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t4_noack%0d", i), {31'b0, sys_ack}, 32'd0);
      tick();
    end

    // 5: early release by go in SHOW cycle 2, then back-to-back request
    v0 = 32'd1; a0 = 32'h00000042; sys_req = 1'b1;
    tick();
    tick();
    go = 1'b1;
    #1;
    chk("t5_show2_valid", {31'b0, disp_valid}, 32'd1);
    tick();
    chk("t5_early_ack", {31'b0, sys_ack}, 32'd1);
    v0 = 32'd5;
    tick();
    chk("t5_idle_noack", {31'b0, sys_ack}, 32'd0);
    chk("t5_b2b_stall", {31'b0, stall}, 32'd1);
    chk("t5_cnt1", {16'b0, sys_cnt}, 32'd1);
    tick();
    chk("t5_b2b_ack", {31'b0, sys_ack}, 32'd1);
    sys_req = 1'b0; go = 1'b0;
    tick();
    chk("t5_cnt2", {16'b0, sys_cnt}, 32'd2);
    chk("t5_disp", disp_data, 32'h00000042);

    // 6: print-char sequence "MIPS"
    chars = 32'h4D495053;
    for (int i = 0; i < 4; i++) begin
      v0 = 32'd11; a0 = {24'h0, chars[31-8*i -: 8]}; sys_req = 1'b1;
      tick();
`ifdef SYSCALL_CHAR_EN
      chk($sformatf("t6_char%0d_valid", i), {31'b0, disp_valid}, 32'd1);
      tick();
`endif
      chk($sformatf("t6_char%0d_ack", i), {31'b0, sys_ack}, 32'd1);
      sys_req = 1'b0;
      tick();
    end
`ifdef SYSCALL_CHAR_EN
    exp_disp = 32'h4D495053;
`else
    exp_disp = 32'h00000042;
`endif
    chk("t6_disp", disp_data, exp_disp);
    chk("t6_cnt", {16'b0, sys_cnt}, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
